// File: rtl/ili9341_pkg.sv
// Shared opcodes, receiver state encoding and default window limits for the
// ILI9341 8080-style write bus; the bus driver imports the same opcodes.
package ili9341_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

  localparam int unsigned DEF_COL_MAX  = 239;
  localparam int unsigned DEF_PAGE_MAX = 319;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_OTHER
  } rx_state_e;

  // Window parameters arrive big-endian; the panel only uses 9 bits.
  function automatic logic [8:0] param_coord(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[0], lo};
  endfunction

endpackage

// File: rtl/ili9341_cursor.sv
// Column/page window registers and the RAM write cursor that walks them.
module ili9341_cursor
  import ili9341_pkg::*;
#(
  parameter int unsigned COL_MAX  = DEF_COL_MAX,
  parameter int unsigned PAGE_MAX = DEF_PAGE_MAX
) (
  input  logic       clk_16MHz,
  input  logic       reset,
  input  logic       load_start_i,
  input  logic       step_i,
  input  logic       commit_col_i,
  input  logic       commit_page_i,
  input  logic       restore_defaults_i,
  input  logic [8:0] start_i,
  input  logic [8:0] end_i,
  output logic [8:0] x_o,
  output logic [8:0] y_o,
  output logic       at_end_o
);

  logic [8:0] sc_q, ec_q, sp_q, ep_q, x_q, y_q;
  logic [8:0] sc_d, ec_d, sp_d, ep_d, x_d, y_d;

  always_comb begin
    // NOTE: every combinational output starts from a default so no path leaves it unassigned (no latch).
    sc_d = sc_q;
    ec_d = ec_q;
    sp_d = sp_q;
    ep_d = ep_q;
    x_d  = x_q;
    y_d  = y_q;

    if (restore_defaults_i) begin
      sc_d = '0;
      ec_d = 9'(COL_MAX);
      sp_d = '0;
      ep_d = 9'(PAGE_MAX);
    end else begin
      if (commit_col_i) begin
        sc_d = start_i;
        ec_d = end_i;
      end
      if (commit_page_i) begin
        sp_d = start_i;
        ep_d = end_i;
      end
    end

    // x wraps naturally at 511, which lets a start column above the end column still reach it.
    if (load_start_i) begin
      x_d = sc_q;
      y_d = sp_q;
    end else if (step_i) begin
      if (x_q == ec_q) begin
        x_d = sc_q;
        y_d = (y_q == ep_q) ? sp_q : y_q + 9'd1;
      end else begin
        x_d = x_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk_16MHz or posedge reset) begin
    if (reset) begin
      sc_q <= '0;
      ec_q <= 9'(COL_MAX);
      sp_q <= '0;
      ep_q <= 9'(PAGE_MAX);
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      sc_q <= sc_d;
      ec_q <= ec_d;
      sp_q <= sp_d;
      ep_q <= ep_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign at_end_o = (x_q == ec_q) && (y_q == ep_q);

endmodule

// File: rtl/ili9341_bus_rx.sv
// Panel-side decoder for the ILI9341 write bus: commands, window setup and
// RAM writes turned into addressed RGB565 pixels.
module ili9341_bus_rx
  import ili9341_pkg::*;
#(
  parameter int unsigned COL_MAX  = DEF_COL_MAX,
  parameter int unsigned PAGE_MAX = DEF_PAGE_MAX
) (
  input  logic        clk_16MHz,
  input  logic        reset,
  input  logic        ncs,
  input  logic        cmd_data,
  input  logic        write_edge,
  input  logic [7:0]  din,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        pix_valid,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        frame_done,
  output logic        disp_on,
  output logic        awake
);

  rx_state_e   state_q, state_d;
  logic        we_q;
  logic [1:0]  param_idx_q, param_idx_d;
  logic        byte_phase_q, byte_phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  shadow_q [4];
  logic [7:0]  shadow_d [4];

  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic        pix_valid_q, pix_valid_d;
  logic [8:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic        frame_done_q, frame_done_d;
  logic        disp_on_q, disp_on_d;
  logic        awake_q, awake_d;

  logic        strobe;
  logic        load_start, step, commit_col, commit_page, restore_defaults;
  logic [8:0]  win_start, win_end;
  logic [8:0]  cur_x, cur_y;
  logic        cur_at_end;

  // A held-high strobe counts once; deselected strobes still advance we_q.
  assign strobe = write_edge & ~we_q & ~ncs;

  ili9341_cursor #(
    .COL_MAX  (COL_MAX),
    .PAGE_MAX (PAGE_MAX)
  ) u_cursor (
    .clk_16MHz          (clk_16MHz),
    .reset              (reset),
    .load_start_i       (load_start),
    .step_i             (step),
    .commit_col_i       (commit_col),
    .commit_page_i      (commit_page),
    .restore_defaults_i (restore_defaults),
    .start_i            (win_start),
    .end_i              (win_end),
    .x_o                (cur_x),
    .y_o                (cur_y),
    .at_end_o           (cur_at_end)
  );

  always_comb begin
    state_d          = state_q;
    param_idx_d      = param_idx_q;
    byte_phase_d     = byte_phase_q;
    hi_d             = hi_q;
    shadow_d         = shadow_q;
    cmd_valid_d      = 1'b0;
    cmd_byte_d       = cmd_byte_q;
    pix_valid_d      = 1'b0;
    pix_x_d          = pix_x_q;
    pix_y_d          = pix_y_q;
    pix_data_d       = pix_data_q;
    frame_done_d     = 1'b0;
    disp_on_d        = disp_on_q;
    awake_d          = awake_q;
    load_start       = 1'b0;
    step             = 1'b0;
    commit_col       = 1'b0;
    commit_page      = 1'b0;
    restore_defaults = 1'b0;
    win_start        = '0;
    win_end          = '0;

    if (strobe && !cmd_data) begin
      cmd_valid_d  = 1'b1;
      cmd_byte_d   = din;
      param_idx_d  = '0;
      byte_phase_d = 1'b0;
      case (din)
        CMD_CASET:   state_d = ST_CASET;
        CMD_PASET:   state_d = ST_PASET;
        CMD_RAMWR: begin
          state_d    = ST_RAMWR;
          load_start = 1'b1;
        end
        CMD_RAMWRC:  state_d = ST_RAMWR;
        CMD_SWRESET: begin
          state_d          = ST_IDLE;
          restore_defaults = 1'b1;
          disp_on_d        = 1'b0;
          awake_d          = 1'b0;
        end
        CMD_SLPIN: begin
          state_d = ST_IDLE;
          awake_d = 1'b0;
        end
        CMD_SLPOUT: begin
          state_d = ST_IDLE;
          awake_d = 1'b1;
        end
        CMD_DISPOFF: begin
          state_d   = ST_IDLE;
          disp_on_d = 1'b0;
        end
        CMD_DISPON: begin
          state_d   = ST_IDLE;
          disp_on_d = 1'b1;
        end
        default:     state_d = ST_OTHER;
      endcase
    end else if (strobe) begin
      case (state_q)
        ST_CASET, ST_PASET: begin
          shadow_d[param_idx_q] = din;
          param_idx_d           = param_idx_q + 2'd1;
          // Start and end land together on the fourth byte, so a partial set never disturbs the window.
          if (param_idx_q == 2'd3) begin
            win_start   = param_coord(shadow_q[0], shadow_q[1]);
            win_end     = param_coord(shadow_q[2], din);
            commit_col  = (state_q == ST_CASET);
            commit_page = (state_q == ST_PASET);
            state_d     = ST_OTHER;
          end
        end
        ST_RAMWR: begin
          if (!byte_phase_q) begin
            hi_d         = din;
            byte_phase_d = 1'b1;
          end else begin
            pix_valid_d  = 1'b1;
            pix_x_d      = cur_x;
            pix_y_d      = cur_y;
            pix_data_d   = {hi_q, din};
            frame_done_d = cur_at_end;
            byte_phase_d = 1'b0;
            step         = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_16MHz or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      param_idx_q  <= '0;
      byte_phase_q <= 1'b0;
      hi_q         <= '0;
      shadow_q     <= '{default: '0};
      cmd_valid_q  <= 1'b0;
      cmd_byte_q   <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_data_q   <= '0;
      frame_done_q <= 1'b0;
      disp_on_q    <= 1'b0;
      awake_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= write_edge;
      param_idx_q  <= param_idx_d;
      byte_phase_q <= byte_phase_d;
      hi_q         <= hi_d;
      shadow_q     <= shadow_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_byte_q   <= cmd_byte_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_data_q   <= pix_data_d;
      frame_done_q <= frame_done_d;
      disp_on_q    <= disp_on_d;
      awake_q      <= awake_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_byte   = cmd_byte_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_data   = pix_data_q;
  assign frame_done = frame_done_q;
  assign disp_on    = disp_on_q;
  assign awake      = awake_q;

endmodule

// File: tb/tb_ili9341_bus_rx.sv
// Directed bench for ili9341_bus_rx: bytes are driven on the falling edge and
// outputs sampled on the falling edge after the accepting rising edge.
module tb_ili9341_bus_rx;
  import ili9341_pkg::*;

  logic        clk_16MHz  = 1'b0;
  logic        reset      = 1'b1;
  logic        ncs        = 1'b1;
  logic        cmd_data   = 1'b0;
  logic        write_edge = 1'b0;
  logic [7:0]  din        = '0;
  logic        cmd_valid, pix_valid, frame_done, disp_on, awake;
  logic [7:0]  cmd_byte;
  logic [8:0]  pix_x, pix_y;
  logic [15:0] pix_data;

  ili9341_bus_rx dut (
    .clk_16MHz  (clk_16MHz),
    .reset      (reset),
    .ncs        (ncs),
    .cmd_data   (cmd_data),
    .write_edge (write_edge),
    .din        (din),
    .cmd_valid  (cmd_valid),
    .cmd_byte   (cmd_byte),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_data   (pix_data),
    .frame_done (frame_done),
    .disp_on    (disp_on),
    .awake      (awake)
  );

  always #5 clk_16MHz = ~clk_16MHz;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs captured one cycle after the most recent strobe, plus any pulse seen a cycle later.
  logic        s_cmd_valid, s_pix_valid, s_fd, s_after, s_hi_pv;
  logic [7:0]  s_cmd_byte;
  logic [8:0]  s_x, s_y;
  logic [15:0] s_data;

  task automatic send(input logic dc, input logic [7:0] b);
    @(negedge clk_16MHz);
    cmd_data   = dc;
    din        = b;
    write_edge = 1'b1;
    @(negedge clk_16MHz);
    write_edge  = 1'b0;
    s_cmd_valid = cmd_valid;
    s_cmd_byte  = cmd_byte;
    s_pix_valid = pix_valid;
    s_x         = pix_x;
    s_y         = pix_y;
    s_data      = pix_data;
    s_fd        = frame_done;
    @(negedge clk_16MHz);
    s_after = cmd_valid | pix_valid | frame_done;
  endtask

  task automatic cmd(input logic [7:0] b);
    send(1'b0, b);
  endtask

  task automatic dat(input logic [7:0] b);
    send(1'b1, b);
  endtask

  task automatic pixel(input logic [15:0] d);
    dat(d[15:8]);
    s_hi_pv = s_pix_valid;
    dat(d[7:0]);
  endtask

  task automatic expect_pix(input string tag, input int x, input int y, input int d, input int fd);
    check({tag, ".hi_no_pix"}, 32'(s_hi_pv), 0);
    check({tag, ".valid"}, 32'(s_pix_valid), 1);
    check({tag, ".x"}, 32'(s_x), x);
    check({tag, ".y"}, 32'(s_y), y);
    check({tag, ".data"}, 32'(s_data), d);
    check({tag, ".frame_done"}, 32'(s_fd), fd);
    check({tag, ".one_cycle"}, 32'(s_after), 0);
  endtask

  task automatic do_reset();
    @(negedge clk_16MHz);
    reset = 1'b1;
    repeat (2) @(negedge clk_16MHz);
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".cmd_valid"}, 32'(cmd_valid), 0);
    check({tag, ".cmd_byte"}, 32'(cmd_byte), 0);
    check({tag, ".pix_valid"}, 32'(pix_valid), 0);
    check({tag, ".pix_x"}, 32'(pix_x), 0);
    check({tag, ".pix_y"}, 32'(pix_y), 0);
    check({tag, ".pix_data"}, 32'(pix_data), 0);
    check({tag, ".frame_done"}, 32'(frame_done), 0);
    check({tag, ".disp_on"}, 32'(disp_on), 0);
    check({tag, ".awake"}, 32'(awake), 0);
  endtask

  initial begin
    int cnt, fd_cnt, pv_cnt;
    logic [8:0] fd_x, fd_y;

    repeat (3) @(negedge clk_16MHz);
    reset = 1'b0;
    ncs   = 1'b0;
    @(negedge clk_16MHz);
    check_reset_outputs("reset");

    // Default window stream.
    cmd(CMD_RAMWR);
    check("ramwr.cmd_valid", 32'(s_cmd_valid), 1);
    check("ramwr.cmd_byte", 32'(s_cmd_byte), 32'h2C);
    check("ramwr.cmd_one_cycle", 32'(s_after), 0);
    pixel(16'hF800);
    expect_pix("def_p0", 0, 0, 16'hF800, 0);
    pixel(16'h07E0);
    expect_pix("def_p1", 1, 0, 16'h07E0, 0);

    // 2x2 window at columns 10..11, pages 5..6.
    cmd(CMD_CASET); dat(8'h00); dat(8'h0A); dat(8'h00); dat(8'h0B);
    cmd(CMD_PASET); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
    cmd(CMD_RAMWR);
    pixel(16'h1111); expect_pix("win_p0", 10, 5, 16'h1111, 0);
    pixel(16'h2222); expect_pix("win_p1", 11, 5, 16'h2222, 0);
    pixel(16'h3333); expect_pix("win_p2", 10, 6, 16'h3333, 0);
    pixel(16'h4444); expect_pix("win_p3", 11, 6, 16'h4444, 1);
    pixel(16'h5555); expect_pix("win_p4", 10, 5, 16'h5555, 0);

    // Partial CASET leaves the default window; a fifth parameter is ignored.
    do_reset();
    cmd(CMD_CASET); dat(8'h00); dat(8'h10);
    cmd(CMD_RAMWR);
    pixel(16'hABCD); expect_pix("part_p0", 0, 0, 16'hABCD, 0);
    pixel(16'h0102); expect_pix("part_p1", 1, 0, 16'h0102, 0);
    cmd(CMD_CASET); dat(8'h00); dat(8'h02); dat(8'h00); dat(8'h03); dat(8'hFF);
    cmd(CMD_RAMWR);
    pixel(16'h0A0A); expect_pix("extra_p0", 2, 0, 16'h0A0A, 0);
    pixel(16'h0B0B); expect_pix("extra_p1", 3, 0, 16'h0B0B, 0);
    pixel(16'h0C0C); expect_pix("extra_p2", 2, 1, 16'h0C0C, 0);

    // Dangling hi byte is dropped by RAMWRC, which keeps the cursor.
    do_reset();
    cmd(CMD_RAMWR);
    dat(8'hAA);
    check("odd.aa_no_pix", 32'(s_pix_valid), 0);
    cmd(CMD_RAMWRC);
    check("odd.cmd_byte", 32'(s_cmd_byte), 32'h3C);
    pixel(16'h1234); expect_pix("odd_p0", 0, 0, 16'h1234, 0);

    // Deselected strobes and a held-high strobe.
    do_reset();
    cmd(CMD_RAMWR);
    ncs = 1'b1;
    pv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      dat(8'(8'h40 + i));
      if (s_pix_valid || s_cmd_valid) pv_cnt++;
    end
    cmd(CMD_DISPON);
    if (s_cmd_valid) pv_cnt++;
    check("ncs.no_outputs", 32'(pv_cnt), 0);
    check("ncs.disp_on", 32'(disp_on), 0);
    ncs = 1'b0;
    pixel(16'h5A5A); expect_pix("ncs_p0", 0, 0, 16'h5A5A, 0);

    @(negedge clk_16MHz);
    cmd_data   = 1'b0;
    din        = CMD_SLPOUT;
    write_edge = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk_16MHz);
      if (cmd_valid) cnt++;
    end
    write_edge = 1'b0;
    check("held.cmd_count", 32'(cnt), 1);
    check("held.awake", 32'(awake), 1);
    check("dispon.before", 32'(disp_on), 0);
    @(negedge clk_16MHz);
    din        = CMD_DISPON;
    write_edge = 1'b1;
    check("dispon.strobe_cycle", 32'(disp_on), 0);
    @(negedge clk_16MHz);
    write_edge = 1'b0;
    check("dispon.next_cycle", 32'(disp_on), 1);
    cmd(CMD_DISPOFF);
    check("dispoff.disp_on", 32'(disp_on), 0);
    check("dispoff.awake", 32'(awake), 1);

    // Last page only, then SWRESET and continue through the default end to (0,0).
    do_reset();
    cmd(CMD_PASET); dat(8'h01); dat(8'h3F); dat(8'h01); dat(8'h3F);
    cmd(CMD_RAMWR);
    fd_cnt = 0; pv_cnt = 0; fd_x = '0; fd_y = '0;
    for (int i = 0; i < 240; i++) begin
      pixel(16'(i));
      if (s_pix_valid) pv_cnt++;
      if (s_fd) begin
        fd_cnt++;
        fd_x = s_x;
        fd_y = s_y;
      end
    end
    check("row.pix_count", 32'(pv_cnt), 240);
    check("row.fd_count", 32'(fd_cnt), 1);
    check("row.fd_x", 32'(fd_x), 239);
    check("row.fd_y", 32'(fd_y), 319);
    cmd(CMD_SLPOUT);
    cmd(CMD_DISPON);
    cmd(CMD_SWRESET);
    check("swreset.disp_on", 32'(disp_on), 0);
    check("swreset.awake", 32'(awake), 0);
    cmd(CMD_RAMWRC);
    fd_cnt = 0; fd_x = '0; fd_y = '0;
    for (int i = 0; i < 240; i++) begin
      pixel(16'(16'h8000 + i));
      if (s_fd) begin
        fd_cnt++;
        fd_x = s_x;
        fd_y = s_y;
      end
    end
    check("full.fd_count", 32'(fd_cnt), 1);
    check("full.fd_last", 32'(s_fd), 1);
    check("full.fd_x", 32'(fd_x), 239);
    check("full.fd_y", 32'(fd_y), 319);
    pixel(16'hBEEF); expect_pix("wrap_p0", 0, 0, 16'hBEEF, 0);

    // Async reset while the low byte is being strobed.
    cmd(CMD_SLPOUT);
    cmd(CMD_RAMWR);
    dat(8'hC3);
    @(negedge clk_16MHz);
    cmd_data   = 1'b1;
    din        = 8'h3C;
    write_edge = 1'b1;
    #2 reset = 1'b1;
    @(negedge clk_16MHz);
    write_edge = 1'b0;
    check_reset_outputs("midrst");
    @(negedge clk_16MHz);
    reset = 1'b0;
    dat(8'h55);
    check("midrst.no_pix_after", 32'(s_pix_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ili9341_bus_rx.md
# ili9341_bus_rx

Receive-side decoder for the ILI9341 8080-style write bus (8-bit data, D/C select, active-low chip select, rising-edge write strobe). It sits on the panel side of the bus, in the same clock domain as the bus driver, and interprets the command and parameter stream. It tracks column/page windows and the write cursor, and emits one addressed 16-bit RGB565 pixel per two RAM-write data bytes. It serves as a bus-level panel model for simulation and as the front end of an on-chip shadow framebuffer.

## Interface
Parameters:
- COL_MAX, 239, default end column after reset or SWRESET
- PAGE_MAX, 319, default end page after reset or SWRESET

Ports:
- clk_16MHz  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- ncs  in  1  chip select, low = selected
- cmd_data  in  1  1 = data/parameter byte, 0 = command byte
- write_edge  in  1  write strobe; a byte is accepted on its 0->1 transition
- din  in  8  bus byte
- cmd_valid  out  1  one-cycle pulse: command byte accepted
- cmd_byte  out  8  last accepted command opcode
- pix_valid  out  1  one-cycle pulse: pixel complete
- pix_x  out  9  column of emitted pixel
- pix_y  out  9  page (row) of emitted pixel
- pix_data  out  16  RGB565 pixel, first byte in [15:8]
- frame_done  out  1  one-cycle pulse with pix_valid when the pixel is at (end column, end page)
- disp_on  out  1  display-on flag (0x29 sets, 0x28 clears)
- awake  out  1  sleep-out flag (0x11 sets, 0x10 clears)

## Operation
- Edge detect: we_q <= write_edge. Strobe = write_edge & ~we_q & ~ncs. Strobes with ncs=1 are ignored, and we_q still updates.
- Command strobe (cmd_data=0): sets cmd_byte, pulses cmd_valid, clears param_idx (2 bits) and byte_phase, then enters the state selected by opcode:
  - 0x2A -> CASET
  - 0x2B -> PASET
  - 0x2C -> RAMWR; cursor loaded to (SC, SP)
  - 0x3C -> RAMWR; cursor kept
  - 0x01 -> window restored to defaults, disp_on=0, awake=0, state IDLE
  - 0x10 / 0x11 / 0x28 / 0x29 -> update flags, state IDLE
  - all others -> OTHER
- Data strobe, by state:
  - IDLE / OTHER: byte discarded.
  - CASET / PASET: byte stored in 4-entry shadow at param_idx, param_idx++. On the 4th byte, start = {b0,b1}[8:0] and end = {b2,b3}[8:0] are committed atomically, then state OTHER, so extra parameters are ignored. A new command before the 4th byte discards the partial set and leaves the window unchanged.
  - RAMWR, byte_phase 0: byte held as hi, byte_phase=1.
  - RAMWR, byte_phase 1: emit pixel {hi, din} at the cursor, byte_phase=0, then advance the cursor:
    - if x==EC: x<=SC, and y<=SP when y==EP, else y+1
    - else: x<=x+1 (9-bit, wraps at 511, which covers SC>EC)
  - A dangling hi byte is dropped by any command.
- State encoding: IDLE, CASET, PASET, RAMWR, OTHER.
- Reset values:
  - outputs: cmd_valid=0, pix_valid=0, frame_done=0, cmd_byte=0x00, pix_x=0, pix_y=0, pix_data=0, disp_on=0, awake=0
  - internal: SC=0, EC=COL_MAX, SP=0, EP=PAGE_MAX, cursor (0,0), state IDLE, we_q=0
- Reset mid-sequence: everything returns to reset values immediately; no pulse is emitted.

## Timing
- All outputs registered. A strobe detected in cycle N produces cmd_valid/pix_valid/frame_done high in cycle N+1 only, with pix_x/pix_y/pix_data valid in that same cycle and held until the next pixel.
- Minimum accepted strobe spacing is 2 cycles (write_edge high 1 cycle, low at least 1 cycle). A write_edge held high counts once.
- Flags and window registers update in cycle N+1.
- No back-pressure; no busy output.

## Structure
- Package ili9341_pkg: opcode localparams (CMD_SWRESET 0x01, SLPIN 0x10, SLPOUT 0x11, DISPOFF 0x28, DISPON 0x29, CASET 0x2A, PASET 0x2B, RAMWR 0x2C, RAMWRC 0x3C), state encoding, default window constants. The existing bus driver is to import the same opcodes.
- Sub-module ili9341_cursor: holds x/y and SC/EC/SP/EP; inputs load_start, step, commit_col, commit_page, restore_defaults; outputs x, y, at_end.

## Test plan
- Reset-default stream: 0x2C then bytes F8,00,07,E0 -> pixels (0,0)=F800 and (1,0)=07E0, each pix_valid a single cycle.
- Window: 2A 00 0A 00 0B, 2B 00 05 00 06, 2C, 8 bytes -> pixels at (10,5),(11,5),(10,6),(11,6). frame_done only on the 4th pixel; a 5th pixel lands at (10,5).
- Partial CASET: 2A 00 10 then 2C -> window unchanged, first pixel at (0,0). Extra 5th CASET parameter is ignored.
- Odd byte then 0x3C: 2C, AA, 3C, 12, 34 -> single pixel 0x1234 at cursor (0,0); the AA byte is dropped.
- ncs=1 strobes and a held-high write_edge generate no outputs. Sequence 11, 29, 28 -> awake=1 and disp_on toggles 1 then 0, each one cycle after its strobe.
- Full-screen wrap: 240x320 pixels after reset -> frame_done on (239,319); the next pixel lands at (0,0). Async reset asserted mid-pixel -> no pix_valid, all outputs at reset values.
